divided_tick_counter: RTL and testbench

//  Downstream consumer of the power-of-five clock divider's active-low Output.

---
 rtl/divided_tick_counter_pkg.sv | 16 +
 rtl/divided_tick_counter_bcd_digit.sv | 36 +++
 rtl/divided_tick_counter.sv | 112 +++++++++++
 tb/tb_divided_tick_counter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divided_tick_counter_pkg.sv
// Shared types and constants for the divided tick counter.
//   state_t  : control FSM encoding (IDLE, RUN, HOLD)
//   DIGIT_W  : bits per BCD digit
//   BCD_MAX  : largest legal BCD digit value
package divided_tick_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

endpackage : divided_tick_counter_pkg

// File: rtl/divided_tick_counter_bcd_digit.sv
// One decade of the BCD event counter.
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   asynchronous active-low reset, clears Digit
//   Clear  in   synchronous clear, wins over Inc
//   Inc    in   advance this digit by one
//   Digit  out  current value, always 0..9
//   Carry  out  combinational; Inc while Digit is 9 (rolls the next decade)
module bcd_digit
    import divided_tick_counter_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Clear,
    input  logic               Inc,
    output logic [DIGIT_W-1:0] Digit,
    output logic               Carry
);

    logic at_max;

    assign at_max = (Digit == BCD_MAX);
    assign Carry  = Inc & at_max;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Digit <= '0;
        end else if (Clear) begin
            Digit <= '0;
        end else if (Inc) begin
            // 9 wraps straight to 0 so A..F can never appear
            Digit <= at_max ? '0 : Digit + 4'd1;
        end
    end

endmodule : bcd_digit

// File: rtl/divided_tick_counter.sv
// Counts falling edges of the clock divider's active-low output.
// DivIn is synchronised, each falling edge becomes a one-cycle Tick, and
// Ticks are accumulated in a BCD counter while the control FSM is in RUN.
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous active-low reset
//   DivIn     in   divider output, idles high, low marks an event
//   Start     in   level; enter or resume counting
//   Stop      in   level; freeze the count
//   Clear     in   level; zero count and overflow, go to IDLE
//   Tick      out  one-cycle pulse per DivIn falling edge (all states)
//   Running   out  high while the FSM is in RUN
//   Count     out  packed BCD, digit 0 in [3:0]
//   Overflow  out  sticky flag, set when the all-9s value wraps
// Handshake: there is no valid/ready pairing here; Start/Stop/Clear are
// plain levels sampled every cycle and Tick is an unacknowledged pulse.
module divided_tick_counter
    import divided_tick_counter_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      DivIn,
    input  logic                      Start,
    input  logic                      Stop,
    input  logic                      Clear,
    output logic                      Tick,
    output logic                      Running,
    output logic [DIGITS*DIGIT_W-1:0] Count,
    output logic                      Overflow
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   tick_next;
    logic                   count_inc;
    logic [DIGITS:0]        carry;
    state_t                 state;
    state_t                 state_next;

    // Synchroniser and edge history reset high so an idle-high input
    // produces no spurious edge when reset releases.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync <= '1;
            hist <= 1'b1;
            Tick <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], DivIn};
            hist <= sync[SYNC_STAGES-1];
            Tick <= tick_next;
        end
    end

    assign tick_next = hist & ~sync[SYNC_STAGES-1];

    // The count advances on the same edge that raises Tick, using the
    // state before this edge's transition: a tick with Stop in RUN still
    // counts, a tick with Start in IDLE/HOLD does not.
    assign count_inc = tick_next & (state == RUN) & ~Clear;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (Clear) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: if (Start) state_next = RUN;
                RUN:  if (Stop)  state_next = HOLD;
                HOLD: if (Start) state_next = RUN;
                default:         state_next = IDLE;
            endcase
        end
    end

    assign Running = (state == RUN);

    assign carry[0] = count_inc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .Clock (Clock),
            .Reset (Reset),
            .Clear (Clear),
            .Inc   (carry[g]),
            .Digit (Count[g*DIGIT_W +: DIGIT_W]),
            .Carry (carry[g+1])
        );
    end

    // Carry out of the top digit means the all-9s value just wrapped to 0.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Overflow <= 1'b0;
        end else if (Clear) begin
            Overflow <= 1'b0;
        end else if (carry[DIGITS]) begin
            Overflow <= 1'b1;
        end
    end

endmodule : divided_tick_counter

// File: tb/tb_divided_tick_counter.sv
// Directed bench for divided_tick_counter (DIGITS=4, SYNC_STAGES=2).
module tb_divided_tick_counter;

    logic        clock;
    logic        reset;
    logic        div_in;
    logic        start;
    logic        stop;
    logic        clear;
    logic        tick;
    logic        running;
    logic [15:0] count;
    logic        overflow;

    int vectors   = 0;
    int errors    = 0;
    int tick_seen = 0;
    int bad_digit = 0;
    int ticks_before;
    logic [15:0] exp_q[$];

    divided_tick_counter #(.DIGITS(4), .SYNC_STAGES(2)) dut (
        .Clock    (clock),
        .Reset    (reset),
        .DivIn    (div_in),
        .Start    (start),
        .Stop     (stop),
        .Clear    (clear),
        .Tick     (tick),
        .Running  (running),
        .Count    (count),
        .Overflow (overflow)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Tick pulse counter and BCD legality monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (reset) begin
            if (tick) tick_seen++;
            for (int d = 0; d < 4; d++) begin
                if (count[d*4 +: 4] > 4'd9) bad_digit++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("miscompare at %s", tag);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            div_in = 1'b0;
            step();
            div_in = 1'b1;
            step();
        end
    endtask

    task automatic flush();
        repeat (4) step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        div_in = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        clear  = 1'b0;

        // 1. held in reset with DivIn toggling
        for (int i = 0; i < 5; i++) begin
            div_in = ~div_in;
            step();
            check("rst_tick", {31'd0, tick}, 32'd0);
            check("rst_running", {31'd0, running}, 32'd0);
            check("rst_count", {16'd0, count}, 32'd0);
            check("rst_overflow", {31'd0, overflow}, 32'd0);
        end
        div_in = 1'b1;
        step();
        reset = 1'b1;
        step();
        step();
        check("idle_tick", {31'd0, tick}, 32'd0);

        // 2. first tick latency: low sampled at edge t, Tick raised at t+2
        do_start();
        check("start_running", {31'd0, running}, 32'd1);
        div_in = 1'b0;
        step();                                  // edge t
        check("lat_t0", {31'd0, tick}, 32'd0);
        step();                                  // edge t+1
        check("lat_t1", {31'd0, tick}, 32'd0);
        step();                                  // edge t+2
        check("lat_t2", {31'd0, tick}, 32'd1);
        check("lat_count", {16'd0, count}, 32'h0001);
        step();
        check("lat_t3", {31'd0, tick}, 32'd0);
        repeat (3) step();                       // long low gives one tick
        check("long_low_count", {16'd0, count}, 32'h0001);
        div_in = 1'b1;
        flush();

        // 3. decade carries
        exp_q.push_back(16'h0010);
        exp_q.push_back(16'h0100);
        do_clear();
        do_start();
        pulse(10);
        flush();
        check("count_10", {16'd0, count}, {16'd0, exp_q.pop_front()});
        do_clear();
        do_start();
        pulse(100);
        flush();
        check("count_100", {16'd0, count}, {16'd0, exp_q.pop_front()});

        // 4. wrap at 9999
        do_clear();
        do_start();
        pulse(9999);
        flush();
        check("count_9999", {16'd0, count}, 32'h9999);
        check("ovf_before", {31'd0, overflow}, 32'd0);
        pulse(1);
        flush();
        check("count_wrap", {16'd0, count}, 32'h0000);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        pulse(1);
        flush();
        check("count_after_wrap", {16'd0, count}, 32'h0001);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_clear();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        check("clear_count", {16'd0, count}, 32'h0000);
        check("clear_running", {31'd0, running}, 32'd0);

        // 5. hold freezes count, ticks continue
        do_start();
        pulse(3);
        flush();
        check("run_count3", {16'd0, count}, 32'h0003);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_running", {31'd0, running}, 32'd0);
        ticks_before = tick_seen;
        pulse(5);
        flush();
        check("hold_ticks", tick_seen - ticks_before, 32'd5);
        check("hold_count", {16'd0, count}, 32'h0003);
        check("hold_running", {31'd0, running}, 32'd0);
        do_start();
        check("resume_running", {31'd0, running}, 32'd1);
        pulse(2);
        flush();
        check("resume_count", {16'd0, count}, 32'h0005);

        // tick coinciding with Stop in RUN is counted
        div_in = 1'b0;
        step();
        div_in = 1'b1;
        step();
        stop = 1'b1;
        step();                                  // tick edge
        stop = 1'b0;
        check("stop_tick_count", {16'd0, count}, 32'h0006);
        check("stop_tick_running", {31'd0, running}, 32'd0);
        flush();

        // tick coinciding with Start in HOLD is not counted
        div_in = 1'b0;
        step();
        div_in = 1'b1;
        step();
        start = 1'b1;
        step();                                  // tick edge
        start = 1'b0;
        check("start_tick_count", {16'd0, count}, 32'h0006);
        check("start_tick_running", {31'd0, running}, 32'd1);
        flush();

        // 6. Clear + Start + tick together -> zero and IDLE
        div_in = 1'b0;
        step();
        div_in = 1'b1;
        step();
        clear = 1'b1;
        start = 1'b1;
        step();                                  // tick edge
        clear = 1'b0;
        start = 1'b0;
        check("ccs_count", {16'd0, count}, 32'h0000);
        check("ccs_running", {31'd0, running}, 32'd0);
        pulse(2);
        flush();
        check("idle_no_count", {16'd0, count}, 32'h0000);

        // async reset mid-RUN, checked between clock edges
        do_start();
        pulse(2);
        flush();
        check("pre_reset_count", {16'd0, count}, 32'h0002);
        div_in = 1'b0;
        step();
        step();
        step();                                  // Tick just raised
        #2;
        reset = 1'b0;
        #1;
        check("async_tick", {31'd0, tick}, 32'd0);
        check("async_running", {31'd0, running}, 32'd0);
        check("async_count", {16'd0, count}, 32'h0000);
        check("async_overflow", {31'd0, overflow}, 32'd0);
        div_in = 1'b1;
        step();
        reset = 1'b1;
        step();

        check("bcd_digits_legal", bad_digit, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_divided_tick_counter
